// File: rtl/bio_pkg.sv
// bio_pkg: shared constants for the board I/O front end.
//   - Channel index map for the default 21-channel board:
//     sw[17:0] on channels SW_LO..SW_HI, key1..key3 on KEY1..KEY3.
//   - BIO_N          : number of board input channels.
//   - ACT_LOW_KEYS   : active-low mask covering the pushbuttons (bits 20:18).
//   - DB_CYCLES_50MHZ: debounce length giving 1 ms at a 50 MHz clock.
package bio_pkg;

  localparam int SW_LO = 0;
  localparam int SW_HI = 17;
  localparam int KEY1  = SW_HI + 1;
  localparam int KEY2  = KEY1 + 1;
  localparam int KEY3  = KEY2 + 1;
  localparam int BIO_N = KEY3 + 1;

  // Pushbuttons idle high and pull low when pressed.
  localparam logic [BIO_N-1:0] ACT_LOW_KEYS = (BIO_N'(1) << KEY1)
                                            | (BIO_N'(1) << KEY2)
                                            | (BIO_N'(1) << KEY3);

  localparam int DB_CYCLES_50MHZ = 50000;

endpackage : bio_pkg

// File: rtl/bio_db_chan.sv
// bio_db_chan: one input channel of the board I/O front end.
//   Two-flop synchronizer, debounce counter, debounced level and
//   registered one-cycle rise/fall pulses.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   raw   : unsynchronized board input
//   level : debounced level (same polarity as raw)
//   rise  : one-cycle pulse the cycle after level goes 0->1
//   fall  : one-cycle pulse the cycle after level goes 1->0
// Build option: BIO_DEBOUNCE_BYPASS_EN removes the counter so the level
//   follows the synchronized input every cycle (fast simulation builds).
module bio_db_chan #(
  parameter int   CNT_W     = 16,
  parameter int   DB_CYCLES = 50000,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;
  logic level_r;
  logic level_d_r;
  logic rise_r;
  logic fall_r;
  logic level_nxt_s;

`ifdef BIO_DEBOUNCE_BYPASS_EN

  // Bypass: the level takes the synchronized sample directly.
  always_comb begin
    level_nxt_s = s2_r;
  end

`else

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Count consecutive cycles the synchronized input disagrees with level;
  // accept the new value on the last count, restart on any agreement.
  always_comb begin
    cnt_nxt_s   = '0;
    level_nxt_s = level_r;
    if (s2_r == level_r) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      level_nxt_s = s2_r;
      cnt_nxt_s   = '0;
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Debounce counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

`endif

  // Synchronizer, level, and edge pulses. level_d_r holds the previous
  // level so the pulse lands one cycle after the level update; it resets
  // to the same value as level so leaving reset never produces an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r      <= RST_VAL;
      s2_r      <= RST_VAL;
      level_r   <= RST_VAL;
      level_d_r <= RST_VAL;
      rise_r    <= 1'b0;
      fall_r    <= 1'b0;
    end else begin
      s1_r      <= raw;
      s2_r      <= s1_r;
      level_r   <= level_nxt_s;
      level_d_r <= level_r;
      rise_r    <= level_r & ~level_d_r;
      fall_r    <= ~level_r & level_d_r;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule : bio_db_chan

// File: rtl/bio_debounce.sv
// bio_debounce: board I/O input conditioning for N pushbutton/switch lines.
//   Each channel is synchronized and debounced by bio_db_chan; this level
//   adds the sticky per-channel event flags with write-1-to-clear strobes.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   raw_in : [N] unsynchronized board inputs
//   clr    : [N] write-1-to-clear strobes for evt
//   level  : [N] debounced levels, same polarity as raw_in
//   rise   : [N] one-cycle pulse on level 0->1
//   fall   : [N] one-cycle pulse on level 1->0
//   evt    : [N] sticky flag, set on the activation edge (fall for
//                 ACT_LOW channels, rise otherwise)
// Build option: BIO_DEBOUNCE_BYPASS_EN (see bio_db_chan) skips debouncing.
module bio_debounce
  import bio_pkg::*;
#(
  parameter int             N         = BIO_N,
  parameter int             CNT_W     = 16,
  parameter int             DB_CYCLES = DB_CYCLES_50MHZ,
  parameter logic [N-1:0]   RST_VAL   = '0,
  parameter logic [N-1:0]   ACT_LOW   = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] raw_in,
  input  logic [N-1:0] clr,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] evt
);

  logic [N-1:0] act_s;
  logic [N-1:0] evt_r;

  for (genvar i = 0; i < N; i++) begin : g_chan
    bio_db_chan #(
      .CNT_W     (CNT_W),
      .DB_CYCLES (DB_CYCLES),
      .RST_VAL   (RST_VAL[i])
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_in[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // Activation edge per channel: a press pulls active-low keys down.
  always_comb begin
    act_s = (rise & ~ACT_LOW) | (fall & ACT_LOW);
  end

  // Sticky event flags; a new activation beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_r <= '0;
    end else begin
      evt_r <= act_s | (evt_r & ~clr);
    end
  end

  assign evt = evt_r;

endmodule : bio_debounce

// File: tb/tb_bio_debounce.sv
// Testbench for bio_debounce: directed scenarios plus randomized traffic,
// checked against a window-based reference model of the debounce rules.
module tb_bio_debounce;
  import bio_pkg::*;

  localparam int N  = BIO_N;
  localparam int DB = 4;
`ifdef BIO_DEBOUNCE_BYPASS_EN
  localparam int DB_EFF = 1;
`else
  localparam int DB_EFF = DB;
`endif
  // raw_in step to level change, in clock edges
  localparam int LAT = DB_EFF + 2;
  localparam logic [N-1:0] RST = ACT_LOW_KEYS;
  localparam logic [N-1:0] ACT = ACT_LOW_KEYS;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] raw_in;
  logic [N-1:0] clr;
  logic [N-1:0] level;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] evt;

  int n_checks;
  int n_fail;

  // reference model state
  logic [N-1:0] raw_hist[$];
  logic [N-1:0] raw_cur;
  logic [N-1:0] m_level;
  logic [N-1:0] m_level_prev;
  logic [N-1:0] m_rise;
  logic [N-1:0] m_fall;
  logic [N-1:0] m_evt;

  bio_debounce #(
    .N         (N),
    .CNT_W     (16),
    .DB_CYCLES (DB),
    .RST_VAL   (RST),
    .ACT_LOW   (ACT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (raw_in),
    .clr    (clr),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .evt    (evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    raw_hist.delete();
    for (int k = 0; k < 16; k++) raw_hist.push_back(RST);
    m_level      = RST;
    m_level_prev = RST;
    m_rise       = '0;
    m_fall       = '0;
    m_evt        = '0;
  endtask

  // A bit flips once the last DB_EFF synchronized samples (raw from two
  // edges back and earlier) all disagree with the current level.
  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] c);
    logic [N-1:0] flip;
    flip = '1;
    for (int k = 0; k < DB_EFF; k++)
      flip = flip & (raw_hist[raw_hist.size() - 2 - k] ^ m_level);
    m_evt        = (m_rise & ~ACT) | (m_fall & ACT) | (m_evt & ~c);
    m_rise       = m_level & ~m_level_prev;
    m_fall       = ~m_level & m_level_prev;
    m_level_prev = m_level;
    m_level      = m_level ^ flip;
    raw_hist.push_back(r);
    if (raw_hist.size() > 16) void'(raw_hist.pop_front());
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model on
  // the rising edge, and leave time 1 unit after that edge for sampling.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] c);
    @(negedge clk);
    raw_in  = r;
    clr     = c;
    raw_cur = r;
    @(posedge clk);
    model_edge(r, c);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    raw_in = RST;
    clr    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    raw_cur = RST;
    for (int k = 0; k < 8; k++) begin
      step(RST, '0);
      n_checks++;
      if ({level, rise, fall, evt} !== {RST, {N{1'b0}}, {N{1'b0}}, {N{1'b0}}}) begin
        n_fail++;
        $display("FAIL reset_idle: level/rise/fall/evt = %h/%h/%h/%h, required %h/0/0/0",
                 level, rise, fall, evt, RST);
      end
    end
  endtask

  task automatic test_clean_step();
    logic [N-1:0] r;
    r = raw_cur;
    r[SW_LO] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(r, '0);
      n_checks++;
      if (level[SW_LO] !== (k >= LAT) || rise[SW_LO] !== (k == LAT + 1)) begin
        n_fail++;
        $display("FAIL clean_step edge %0d: level0=%b rise0=%b, required %b %b",
                 k, level[SW_LO], rise[SW_LO], k >= LAT, k == LAT + 1);
      end
    end
    n_checks++;
    if (evt[SW_LO] !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_step_evt: evt0=%b, required 1", evt[SW_LO]);
    end
  endtask

  task automatic test_glitch();
    logic [N-1:0] r;
    r = raw_cur;
    for (int k = 0; k < 11; k++) begin
      r[5] = (k < 3);
      step(r, '0);
      n_checks++;
      if ({level, rise, fall, evt} !== {m_level, m_rise, m_fall, m_evt}) begin
        n_fail++;
        $display("FAIL glitch_model: level/rise/fall/evt = %h/%h/%h/%h, required %h/%h/%h/%h",
                 level, rise, fall, evt, m_level, m_rise, m_fall, m_evt);
      end
`ifndef BIO_DEBOUNCE_BYPASS_EN
      n_checks++;
      if (level[5] !== 1'b0 || rise[5] !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_reject: level5=%b rise5=%b, required 0 0", level[5], rise[5]);
      end
`endif
    end
  endtask

  task automatic test_key_press();
    logic [N-1:0] r;
    int n_fall;
    int n_rise;
    n_fall = 0;
    n_rise = 0;
    r = raw_cur;
    for (int k = 0; k < 20; k++) begin
      r[KEY2] = (k >= 10);
      step(r, '0);
      if (fall[KEY2] === 1'b1) n_fall++;
      if (rise[KEY2] === 1'b1) n_rise++;
      n_checks++;
      if ({level, rise, fall, evt} !== {m_level, m_rise, m_fall, m_evt}) begin
        n_fail++;
        $display("FAIL key_model: level/rise/fall/evt = %h/%h/%h/%h, required %h/%h/%h/%h",
                 level, rise, fall, evt, m_level, m_rise, m_fall, m_evt);
      end
    end
    n_checks++;
    if (n_fall != 1 || n_rise != 1 || evt[KEY2] !== 1'b1) begin
      n_fail++;
      $display("FAIL key_press: fall pulses=%0d rise pulses=%0d evt19=%b, required 1 1 1",
               n_fall, n_rise, evt[KEY2]);
    end
  endtask

  task automatic test_clr_race();
    logic [N-1:0] r;
    logic [N-1:0] c;
    bit seen;
    c = '0;
    c[KEY2] = 1'b1;
    r = raw_cur;
    step(r, c);
    n_checks++;
    if (evt[KEY2] !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_plain: evt19=%b, required 0", evt[KEY2]);
    end
    r[KEY2] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(r, '0);
      seen = (fall[KEY2] === 1'b1);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL clr_race_timeout: fall19 never pulsed, required a pulse within 20 cycles");
    end
    step(r, c);
    n_checks++;
    if (evt[KEY2] !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_race_set_wins: evt19=%b, required 1", evt[KEY2]);
    end
    step(r, c);
    n_checks++;
    if (evt[KEY2] !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_after: evt19=%b, required 0", evt[KEY2]);
    end
    step(r, c);
    n_checks++;
    if ({level, rise, fall, evt} !== {m_level, m_rise, m_fall, m_evt}) begin
      n_fail++;
      $display("FAIL clr_idle: level/rise/fall/evt = %h/%h/%h/%h, required %h/%h/%h/%h",
               level, rise, fall, evt, m_level, m_rise, m_fall, m_evt);
    end
    r[KEY2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(r, '0);
      n_checks++;
      if ({level, rise, fall, evt} !== {m_level, m_rise, m_fall, m_evt}) begin
        n_fail++;
        $display("FAIL clr_release: level/rise/fall/evt = %h/%h/%h/%h, required %h/%h/%h/%h",
                 level, rise, fall, evt, m_level, m_rise, m_fall, m_evt);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] c;
    r = raw_cur;
    for (int k = 0; k < 400; k++) begin
      c = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5, 0) == 0) r[i] = ~r[i];
        if ($urandom_range(7, 0) == 0) c[i] = 1'b1;
      end
      step(r, c);
      n_checks++;
      if ({level, rise, fall, evt} !== {m_level, m_rise, m_fall, m_evt}) begin
        n_fail++;
        $display("FAIL random cycle %0d: level/rise/fall/evt = %h/%h/%h/%h, required %h/%h/%h/%h",
                 k, level, rise, fall, evt, m_level, m_rise, m_fall, m_evt);
      end
    end
  endtask

`ifdef BIO_DEBOUNCE_BYPASS_EN
  task automatic test_bypass_glitch();
    logic [N-1:0] r;
    int n_rise;
    int n_fall;
    n_rise = 0;
    n_fall = 0;
    r = raw_cur;
    r[3] = 1'b0;
    repeat (4) step(r, '0);
    for (int k = 0; k < 8; k++) begin
      r[3] = (k == 0);
      step(r, '0);
      if (rise[3] === 1'b1) n_rise++;
      if (fall[3] === 1'b1) n_fall++;
    end
    n_checks++;
    if (n_rise != 1 || n_fall != 1) begin
      n_fail++;
      $display("FAIL bypass_glitch: rise3 pulses=%0d fall3 pulses=%0d, required 1 1",
               n_rise, n_fall);
    end
  endtask
`endif

  task automatic test_reset_mid_count();
    repeat (3) step(~RST, '0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({level, rise, fall, evt} !== {RST, {N{1'b0}}, {N{1'b0}}, {N{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_async: level/rise/fall/evt = %h/%h/%h/%h, required %h/0/0/0",
               level, rise, fall, evt, RST);
    end
    raw_in = RST;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    raw_cur = RST;
    for (int k = 0; k < 10; k++) begin
      step(RST, '0);
      n_checks++;
      if ({level, rise, fall, evt} !== {m_level, m_rise, m_fall, m_evt}) begin
        n_fail++;
        $display("FAIL reset_release: level/rise/fall/evt = %h/%h/%h/%h, required %h/%h/%h/%h",
                 level, rise, fall, evt, m_level, m_rise, m_fall, m_evt);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_clean_step();
    test_glitch();
    test_key_press();
    test_clr_race();
`ifdef BIO_DEBOUNCE_BYPASS_EN
    test_bypass_glitch();
`endif
    test_random();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bio_debounce
